// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner arbiter for the shared camera-board I2C bus, with a forced idle guard between owners.
// Optional watchdog reclaim of a hung owner is compiled in when I2C_ARB_WATCHDOG_EN is defined.
module i2c_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 250,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic       CLK_50,
    input  logic       RESET_N,
    input  logic [1:0] REQ,
    output logic [1:0] GNT,
    input  logic       SCL_O0,
    input  logic       SDAO0,
    input  logic       SCL_O1,
    input  logic       SDAO1,
    output logic       SDAI,
    output logic       I2C_SCL,
    inout  wire        I2C_SDA,
    output logic       BUSY,
    output logic       TIMEOUT_ERR,
    output logic       ERR_ID,
    input  logic       ERR_CLR
);

    typedef enum logic [1:0] {IDLE, OWN, GUARD} state_t;

    state_t      state, state_next;
    logic        owner, owner_next;
    logic        last, last_next;
    logic [1:0]  gnt_next;
    logic [15:0] guard_cnt, guard_next;
    logic [1:0]  eligible;
    logic        winner;
    logic        own_scl, own_sda;

`ifdef I2C_ARB_WATCHDOG_EN
    logic [23:0] wd_cnt, wd_next;
    logic        err_q, err_next, err_id_q, err_id_next, err_set;
    logic [1:0]  locked, locked_next;
    logic        wd_hit;
`endif

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            GNT       <= 2'b00;
            guard_cnt <= 16'd0;
`ifdef I2C_ARB_WATCHDOG_EN
            wd_cnt    <= 24'd0;
            err_q     <= 1'b0;
            err_id_q  <= 1'b0;
            locked    <= 2'b00;
`endif
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            last      <= last_next;
            GNT       <= gnt_next;
            guard_cnt <= guard_next;
`ifdef I2C_ARB_WATCHDOG_EN
            wd_cnt    <= wd_next;
            err_q     <= err_next;
            err_id_q  <= err_id_next;
            locked    <= locked_next;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        last_next   = last;
        gnt_next    = GNT;
        guard_next  = guard_cnt;
        winner      = 1'b0;
        eligible    = REQ;
`ifdef I2C_ARB_WATCHDOG_EN
        wd_next     = wd_cnt;
        err_set     = 1'b0;
        err_id_next = err_id_q;
        // A timed-out requester stays locked until its REQ is seen low once
        locked_next = locked & REQ;
        eligible    = REQ & ~locked;
        wd_hit      = (wd_cnt == 24'(TIMEOUT_CYCLES - 1));
`endif
        case (state)
            IDLE: begin
                if (|eligible) begin
                    winner     = (eligible == 2'b11) ? ~last : eligible[1];
                    owner_next = winner;
                    last_next  = winner;
                    gnt_next   = winner ? 2'b10 : 2'b01;
                    state_next = OWN;
`ifdef I2C_ARB_WATCHDOG_EN
                    wd_next    = 24'd0;
`endif
                end
            end
            OWN: begin
`ifdef I2C_ARB_WATCHDOG_EN
                if (wd_cnt != 24'hFFFFFF) wd_next = wd_cnt + 24'd1;
`endif
                if (!REQ[owner]) begin
                    gnt_next   = 2'b00;
                    guard_next = 16'd0;
                    state_next = GUARD;
                end
`ifdef I2C_ARB_WATCHDOG_EN
                else if (wd_hit) begin
                    gnt_next            = 2'b00;
                    guard_next          = 16'd0;
                    state_next          = GUARD;
                    err_set             = 1'b1;
                    err_id_next         = owner;
                    locked_next[owner]  = 1'b1;
                end
`endif
            end
            GUARD: begin
                if (guard_cnt == 16'(GUARD_CYCLES - 1)) state_next = IDLE;
                else guard_next = guard_cnt + 16'd1;
            end
            default: state_next = IDLE;
        endcase
`ifdef I2C_ARB_WATCHDOG_EN
        err_next = err_set ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
`endif
    end

    assign own_scl = owner ? SCL_O1 : SCL_O0;
    assign own_sda = owner ? SDAO1 : SDAO0;
    assign I2C_SCL = (state == OWN) ? own_scl : 1'b1;
    assign I2C_SDA = ((state == OWN) && !own_sda) ? 1'b0 : 1'bz;
    assign SDAI    = I2C_SDA;
    assign BUSY    = (state != IDLE);

`ifdef I2C_ARB_WATCHDOG_EN
    assign TIMEOUT_ERR = err_q;
    assign ERR_ID      = err_id_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{ERR_CLR, 24'(TIMEOUT_CYCLES)};
    assign TIMEOUT_ERR   = 1'b0;
    assign ERR_ID        = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed self-checking bench for i2c_bus_arbiter; the watchdog scenario is built when I2C_ARB_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;

    localparam int GUARD   = 250;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic       scl_o0 = 1'b1, sdao0 = 1'b1, scl_o1 = 1'b1, sdao1 = 1'b1;
    logic       sdai, scl, busy, tmo_err, err_id;
    logic       err_clr = 1'b0;
    logic       ext_pd = 1'b0;
    wire        sda_bus;

    int tests_run = 0;
    int tests_failed = 0;

    pullup (sda_bus);
    assign sda_bus = ext_pd ? 1'b0 : 1'bz;

    i2c_bus_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK_50(clk), .RESET_N(rst_n), .REQ(req), .GNT(gnt),
        .SCL_O0(scl_o0), .SDAO0(sdao0), .SCL_O1(scl_o1), .SDAO1(sdao1),
        .SDAI(sdai), .I2C_SCL(scl), .I2C_SDA(sda_bus), .BUSY(busy),
        .TIMEOUT_ERR(tmo_err), .ERR_ID(err_id), .ERR_CLR(err_clr)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req = 2'b00; scl_o0 = 1'b1; sdao0 = 1'b1; scl_o1 = 1'b1; sdao1 = 1'b1;
        err_clr = 1'b0; ext_pd = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        req = 2'b11; scl_o0 = 1'b0; sdao0 = 1'b0;
        rst_n = 1'b0;
        tick(2);
        tests_run++; if (gnt !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_gnt got %b expected 00", gnt); end
        tests_run++; if (scl !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_scl got %b expected 1", scl); end
        tests_run++; if (sda_bus !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_sda got %b expected released(1)", sda_bus); end
        tests_run++; if ({busy, tmo_err, err_id} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags got %b expected 000", {busy, tmo_err, err_id}); end
        do_reset();
    endtask

    task automatic test_single_grant();
        tick(8);
        req = 2'b01;
        #1;
        tests_run++; if (gnt !== 2'b00) begin tests_failed++; $display("[TB] FAIL grant_latency_pre got %b expected 00", gnt); end
        tick(1);
        tests_run++; if ({gnt, busy} !== 3'b011) begin tests_failed++; $display("[TB] FAIL single_grant got %b expected 011", {gnt, busy}); end
        scl_o0 = 1'b0; #1;
        tests_run++; if (scl !== 1'b0) begin tests_failed++; $display("[TB] FAIL owner_scl got %b expected 0", scl); end
        scl_o0 = 1'b1; scl_o1 = 1'b0; sdao1 = 1'b0; #1;
        tests_run++; if ({scl, sda_bus} !== 2'b11) begin tests_failed++; $display("[TB] FAIL nonowner_ignored got %b expected 11", {scl, sda_bus}); end
        scl_o1 = 1'b1; sdao1 = 1'b1;
        req = 2'b00;
        tick(1);
        tests_run++; if ({gnt, busy} !== 3'b001) begin tests_failed++; $display("[TB] FAIL release got %b expected 001", {gnt, busy}); end
        tick(GUARD - 1);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL guard_len_end got busy=%b expected 1", busy); end
        tick(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL guard_done got busy=%b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 2'b11;
        tick(1);
        tests_run++; if (gnt !== 2'b01) begin tests_failed++; $display("[TB] FAIL rr_first got %b expected 01", gnt); end
        req = 2'b10;
        tick(1);
        tests_run++; if (gnt !== 2'b00) begin tests_failed++; $display("[TB] FAIL rr_release got %b expected 00", gnt); end
        req = 2'b11; scl_o0 = 1'b0; sdao0 = 1'b0; #1;
        tests_run++; if ({scl, sda_bus, gnt} !== 4'b1100) begin tests_failed++; $display("[TB] FAIL guard_bus got %b expected 1100", {scl, sda_bus, gnt}); end
        tick(GUARD);
        tests_run++; if ({gnt, busy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL guard_hold got %b expected 000", {gnt, busy}); end
        scl_o0 = 1'b1; sdao0 = 1'b1;
        tick(1);
        tests_run++; if (gnt !== 2'b10) begin tests_failed++; $display("[TB] FAIL rr_second got %b expected 10", gnt); end
        sdao1 = 1'b0; sdao0 = 1'b0; #1;
        tests_run++; if ({sda_bus, sdai} !== 2'b00) begin tests_failed++; $display("[TB] FAIL owner1_sda_low got %b expected 00", {sda_bus, sdai}); end
        sdao1 = 1'b1; #1;
        tests_run++; if ({sda_bus, sdai} !== 2'b11) begin tests_failed++; $display("[TB] FAIL owner1_sda_rel got %b expected 11", {sda_bus, sdai}); end
        ext_pd = 1'b1; #1;
        tests_run++; if (sdai !== 1'b0) begin tests_failed++; $display("[TB] FAIL sdai_pulldown got %b expected 0", sdai); end
        ext_pd = 1'b0; sdao0 = 1'b1;
        req = 2'b01;
        tick(1);
        req = 2'b11;
        tick(GUARD + 1);
        tests_run++; if (gnt !== 2'b01) begin tests_failed++; $display("[TB] FAIL rr_third got %b expected 01", gnt); end
        req = 2'b00;
        tick(GUARD + 2);
    endtask

    task automatic test_reset_mid();
        req = 2'b01;
        tick(1);
        sdao0 = 1'b0; #1;
        tests_run++; if ({gnt, sda_bus} !== 3'b010) begin tests_failed++; $display("[TB] FAIL mid_pre got %b expected 010", {gnt, sda_bus}); end
        @(negedge clk);
        rst_n = 1'b0; #1;
        tests_run++; if ({gnt, sda_bus, scl} !== 4'b0011) begin tests_failed++; $display("[TB] FAIL mid_reset got %b expected 0011", {gnt, sda_bus, scl}); end
        do_reset();
    endtask

`ifdef I2C_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        req = 2'b01;
        tick(1);
        tick(TIMEOUT - 1);
        tests_run++; if (gnt !== 2'b01) begin tests_failed++; $display("[TB] FAIL wd_before got %b expected 01", gnt); end
        tick(1);
        tests_run++; if ({gnt, tmo_err, err_id} !== 4'b0010) begin tests_failed++; $display("[TB] FAIL wd_fire got %b expected 0010", {gnt, tmo_err, err_id}); end
        tick(GUARD + 5);
        tests_run++; if ({gnt, busy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL wd_lockout got %b expected 000", {gnt, busy}); end
        req = 2'b00;
        tick(1);
        req = 2'b01;
        tick(1);
        tests_run++; if ({gnt, tmo_err} !== 3'b011) begin tests_failed++; $display("[TB] FAIL wd_regrant got %b expected 011", {gnt, tmo_err}); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tests_run++; if (tmo_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL wd_clear got %b expected 0", tmo_err); end
        req = 2'b00;
        tick(GUARD + 2);
    endtask
`else
    task automatic test_no_watchdog();
        do_reset();
        req = 2'b01;
        tick(TIMEOUT * 3);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tests_run++; if ({gnt, tmo_err, err_id} !== 4'b0100) begin tests_failed++; $display("[TB] FAIL nowd_hold got %b expected 0100", {gnt, tmo_err, err_id}); end
        req = 2'b00;
        tick(GUARD + 2);
    endtask
`endif

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_reset_mid();
`ifdef I2C_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
